rot_square_ctrl: RTL

ROT_SQUARE_CTRL -- requirements
Module: rot_square_ctrl

---
 rtl/rot_sq_pkg.sv | 38 +++
 rtl/tick_gen.sv | 23 ++
 rtl/rot_square_ctrl.sv | 63 ++++++
 3 files changed

// File: rtl/rot_sq_pkg.sv
// Shared constants and helpers for the rotating-square display: segment patterns,
// digit-enable encoding and the square-position to digit map.
package rot_sq_pkg;

   localparam logic [7:0] SEG_UPPER = 8'h9C;
   localparam logic [7:0] SEG_LOWER = 8'hA3;
   localparam logic [7:0] SEG_BLANK = 8'hFF;
   localparam logic [3:0] AN_OFF    = 4'hF;

   typedef logic [2:0] pos_t;
   typedef logic [1:0] digit_t;

   // Upper square walks left to right across the top (digit 3..0), the lower
   // square walks back right to left (digit 0..3), so cw traces a loop.
   function automatic digit_t pos_to_digit(input pos_t p);
      digit_t d;
      case (p)
         3'd0:    d = 2'd3;
         3'd1:    d = 2'd2;
         3'd2:    d = 2'd1;
         3'd3:    d = 2'd0;
         3'd4:    d = 2'd0;
         3'd5:    d = 2'd1;
         3'd6:    d = 2'd2;
         default: d = 2'd3;
      endcase
      return d;
   endfunction

   function automatic logic [7:0] pos_pattern(input pos_t p);
      return p[2] ? SEG_LOWER : SEG_UPPER;
   endfunction

   function automatic logic [3:0] digit_an(input digit_t d);
      return ~(4'b0001 << d);
   endfunction

endpackage

// File: rtl/tick_gen.sv
// Free-running step counter; tick is high for the single cycle the counter is all-ones.
// tick is a combinational decode of the registered count, so it does not depend on any input.
module tick_gen #(
   parameter int TICK_BITS = 24
) (
   input  logic clk,
   input  logic reset,
   output logic tick
);

   logic [TICK_BITS-1:0] cnt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + TICK_BITS'(1);
      end
   end

   assign tick = &cnt;

endmodule

// File: rtl/rot_square_ctrl.sv
// Rotating-square controller for a 4-digit multiplexed 7-segment display.
// Position steps on tick when enabled; an/sseg are registered, one clock after refresh count and pos.
module rot_square_ctrl
   import rot_sq_pkg::*;
#(
   parameter int TICK_BITS    = 24,
   parameter int REFRESH_BITS = 18
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       en,
   input  logic       cw,
   input  logic       disp_on,
   output logic [3:0] an,
   output logic [7:0] sseg,
   output logic [2:0] pos,
   output logic       tick
);

   logic [REFRESH_BITS-1:0] refresh;
   digit_t                  scan;

   tick_gen #(
      .TICK_BITS (TICK_BITS)
   ) u_tick_gen (
      .clk   (clk),
      .reset (reset),
      .tick  (tick)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         refresh <= '0;
      end else begin
         refresh <= refresh + REFRESH_BITS'(1);
      end
   end

   assign scan = refresh[REFRESH_BITS-1 -: 2];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pos <= '0;
      end else if (tick && en) begin
         pos <= cw ? pos + 3'd1 : pos - 3'd1;
      end
   end

   // Blanking only gates the output registers; counters and pos keep running.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         an   <= AN_OFF;
         sseg <= SEG_BLANK;
      end else if (!disp_on) begin
         an   <= AN_OFF;
         sseg <= SEG_BLANK;
      end else begin
         an   <= digit_an(scan);
         sseg <= (scan == pos_to_digit(pos)) ? pos_pattern(pos) : SEG_BLANK;
      end
   end

endmodule
